cplx_peak_detect: RTL

//  Downstream stage of the complex convolution/correlation unit. Consumes its
//  36-bit {re[17:0],im[17:0]} result bursts and computes |x|^2 = re^2+im^2 per

---
 rtl/cplx_peak_detect_if.sv | 27 ++
 rtl/cplx_peak_detect.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/cplx_peak_detect_if.sv
// Sample/report bundle between the correlation unit, the peak detector and its consumer.
// The master drives bursts in and receives one report per burst.
interface cplx_peak_detect_if #(
    parameter int DW    = 18,
    parameter int IDX_W = 3,
    parameter int LEN_W = 4
);
    logic              in_valid;
    logic [2*DW-1:0]   in_data;
    logic              out_valid;
    logic [2*DW-1:0]   peak_pow;
    logic [IDX_W-1:0]  peak_idx;
    logic [DW-1:0]     peak_re;
    logic [DW-1:0]     peak_im;
    logic [LEN_W-1:0]  burst_len;
    logic              ovf;

    modport master (
        output in_valid, in_data,
        input  out_valid, peak_pow, peak_idx, peak_re, peak_im, burst_len, ovf
    );

    modport slave (
        input  in_valid, in_data,
        output out_valid, peak_pow, peak_idx, peak_re, peak_im, burst_len, ovf
    );
endinterface

// File: rtl/cplx_peak_detect.sv
// Per-burst peak-power search over complex samples: square, sum, keep the best,
// and report it three edges after the last sample of each burst.
//
// state | meaning
// IDLE  | no burst in progress; next valid sample is idx 0
// BURST | burst in progress; counting samples, invalid input closes it
module cplx_peak_detect #(
    parameter int DW      = 18,
    parameter int MAX_LEN = 8,
    parameter int IDX_W   = 3,
    parameter int LEN_W   = 4
) (
    input logic               clk,
    input logic               rst_n,
    cplx_peak_detect_if.slave io_bus
);
    typedef enum logic {IDLE, BURST} state_t;

    state_t                 r_state;
    logic [LEN_W-1:0]       r_cnt;
    logic                   r_ovf_pend;

    logic                   r_s1_vld;
    logic                   r_s1_end;
    logic signed [DW-1:0]   r_s1_re;
    logic signed [DW-1:0]   r_s1_im;
    logic [2*DW-2:0]        r_s1_sq_re;
    logic [2*DW-2:0]        r_s1_sq_im;
    logic [IDX_W-1:0]       r_s1_idx;
    logic [LEN_W-1:0]       r_s1_len;
    logic                   r_s1_ovf;

    logic                   r_s2_vld;
    logic                   r_s2_end;
    logic [2*DW-1:0]        r_s2_pow;
    logic signed [DW-1:0]   r_s2_re;
    logic signed [DW-1:0]   r_s2_im;
    logic [IDX_W-1:0]       r_s2_idx;
    logic [LEN_W-1:0]       r_s2_len;
    logic                   r_s2_ovf;

    logic [2*DW-1:0]        r_best_pow;
    logic signed [DW-1:0]   r_best_re;
    logic signed [DW-1:0]   r_best_im;
    logic [IDX_W-1:0]       r_best_idx;

    logic                   r_out_valid;
    logic [2*DW-1:0]        r_out_pow;
    logic [IDX_W-1:0]       r_out_idx;
    logic [DW-1:0]          r_out_re;
    logic [DW-1:0]          r_out_im;
    logic [LEN_W-1:0]       r_out_len;
    logic                   r_out_ovf;

    logic signed [DW-1:0]   w_re;
    logic signed [DW-1:0]   w_im;
    logic signed [2*DW-1:0] w_prod_re;
    logic signed [2*DW-1:0] w_prod_im;
    logic                   w_room;
    logic                   w_take;

    assign w_re      = $signed(io_bus.in_data[2*DW-1:DW]);
    assign w_im      = $signed(io_bus.in_data[DW-1:0]);
    assign w_prod_re = w_re * w_re;
    assign w_prod_im = w_im * w_im;
    // r_cnt returns to 0 whenever a burst closes, so it doubles as the next sample index
    assign w_room    = (r_cnt < LEN_W'(MAX_LEN));
    assign w_take    = io_bus.in_valid && w_room;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_ovf_pend <= 1'b0;
            r_s1_vld   <= 1'b0;
            r_s1_end   <= 1'b0;
            r_s1_re    <= '0;
            r_s1_im    <= '0;
            r_s1_sq_re <= '0;
            r_s1_sq_im <= '0;
            r_s1_idx   <= '0;
            r_s1_len   <= '0;
            r_s1_ovf   <= 1'b0;
        end else begin
            r_s1_vld   <= w_take;
            r_s1_end   <= 1'b0;
            r_s1_re    <= w_re;
            r_s1_im    <= w_im;
            r_s1_sq_re <= w_prod_re[2*DW-2:0];
            r_s1_sq_im <= w_prod_im[2*DW-2:0];
            r_s1_idx   <= r_cnt[IDX_W-1:0];
            case (r_state)
                IDLE: begin
                    if (io_bus.in_valid) begin
                        r_state <= BURST;
                        r_cnt   <= LEN_W'(1);
                    end
                end
                BURST: begin
                    if (io_bus.in_valid) begin
                        if (w_room) r_cnt <= r_cnt + LEN_W'(1);
                        else        r_ovf_pend <= 1'b1;
                    end else begin
                        r_state    <= IDLE;
                        r_cnt      <= '0;
                        r_ovf_pend <= 1'b0;
                        r_s1_end   <= 1'b1;
                        r_s1_len   <= r_cnt;
                        r_s1_ovf   <= r_ovf_pend;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2_vld    <= 1'b0;
            r_s2_end    <= 1'b0;
            r_s2_pow    <= '0;
            r_s2_re     <= '0;
            r_s2_im     <= '0;
            r_s2_idx    <= '0;
            r_s2_len    <= '0;
            r_s2_ovf    <= 1'b0;
            r_best_pow  <= '0;
            r_best_re   <= '0;
            r_best_im   <= '0;
            r_best_idx  <= '0;
            r_out_valid <= 1'b0;
            r_out_pow   <= '0;
            r_out_idx   <= '0;
            r_out_re    <= '0;
            r_out_im    <= '0;
            r_out_len   <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            r_s2_vld <= r_s1_vld;
            r_s2_end <= r_s1_end;
            r_s2_pow <= {1'b0, r_s1_sq_re} + {1'b0, r_s1_sq_im};
            r_s2_re  <= r_s1_re;
            r_s2_im  <= r_s1_im;
            r_s2_idx <= r_s1_idx;
            r_s2_len <= r_s1_len;
            r_s2_ovf <= r_s1_ovf;

            // strict compare keeps the earliest index on ties
            if (r_s2_vld && ((r_s2_idx == '0) || (r_s2_pow > r_best_pow))) begin
                r_best_pow <= r_s2_pow;
                r_best_re  <= r_s2_re;
                r_best_im  <= r_s2_im;
                r_best_idx <= r_s2_idx;
            end

            // snapshot of best is taken before any following burst's idx-0 load lands
            r_out_valid <= r_s2_end;
            if (r_s2_end) begin
                r_out_pow <= r_best_pow;
                r_out_idx <= r_best_idx;
                r_out_re  <= r_best_re;
                r_out_im  <= r_best_im;
                r_out_len <= r_s2_len;
                r_out_ovf <= r_s2_ovf;
            end
        end
    end

    assign io_bus.out_valid = r_out_valid;
    assign io_bus.peak_pow  = r_out_pow;
    assign io_bus.peak_idx  = r_out_idx;
    assign io_bus.peak_re   = r_out_re;
    assign io_bus.peak_im   = r_out_im;
    assign io_bus.burst_len = r_out_len;
    assign io_bus.ovf       = r_out_ovf;
endmodule
